// File: rtl/brent_kung_adder16.sv
// -----------------------------------------------------------------------------
// brent_kung_adder16
//   Registered adder with a Brent-Kung parallel-prefix carry tree.
//   Computes {Cout,S} <= A + B + Cin on every rising clk edge.
//   The carry tree is combinational. The 17-bit result sits in one output
//   register, so latency is one cycle.
//
// Ports
//   clk    in   1      clock, rising edge active
//   rst_n  in   1      asynchronous reset, active-low (clears S and Cout)
//   A      in   WIDTH  operand A, unsigned
//   B      in   WIDTH  operand B, unsigned
//   Cin    in   1      carry into bit 0
//   S      out  WIDTH  registered sum bits
//   Cout   out  1      registered carry-out (sum bit WIDTH)
// -----------------------------------------------------------------------------

// One prefix node: (G,P) o (G',P') = (G | P&G', P&P').
// The "hi" pair covers the more significant span.
module bk_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

module brent_kung_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int LOG  = $clog2(WIDTH);
  // Level 0 holds the bit-level signals.
  // Levels 1..LOG form the up-sweep.
  // Levels LOG+1..2*LOG-1 form the down-sweep.
  localparam int NLVL = 2 * LOG;

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             unused_p;

  assign g_bit = A & B;
  assign p_bit = A ^ B;

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;

    if (l == 0) begin : g_base
      // Fold Cin into bit 0, so every group generate ending at bit 0
      // already includes the incoming carry.
      assign gg = {g_bit[WIDTH-1:1], g_bit[0] | (p_bit[0] & Cin)};
      assign pp = p_bit;
    end else begin : g_tree
      localparam int UP = (l <= LOG) ? 1 : 0;
      // Span distance for this level.
      // Up-sweep: doubles each level.
      // Down-sweep: halves back toward 1.
      localparam int D  = (UP == 1) ? (1 << (l - 1)) : (1 << (2 * LOG - 1 - l));

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit_node
        // Up-sweep nodes sit at indices 2D-1 mod 2D.
        // Down-sweep nodes sit at indices D-1 mod 2D that are not yet
        // complete (i >= 2D). Each of them picks up the finished prefix
        // just below its own span.
        localparam bit COMBINE = (UP == 1) ? (((i + 1) % (2 * D)) == 0)
                                           : ((((i + 1) % (2 * D)) == D) && (i >= 2 * D));
        if (COMBINE) begin : g_cell
          bk_prefix_cell u_cell (
            .g_hi  (g_lvl[l-1].gg[i]),
            .p_hi  (g_lvl[l-1].pp[i]),
            .g_lo  (g_lvl[l-1].gg[i-D]),
            .p_lo  (g_lvl[l-1].pp[i-D]),
            .g_out (gg[i]),
            .p_out (pp[i])
          );
        end else begin : g_pass
          assign gg[i] = g_lvl[l-1].gg[i];
          assign pp[i] = g_lvl[l-1].pp[i];
        end
      end
    end
  end

  // After the last level, gg[i] is G[i:0] with Cin included, which is c[i+1].
  assign carry = {g_lvl[NLVL-1].gg, Cin};

  // Group propagates of the finished prefixes are never needed.
  assign unused_p = ^g_lvl[NLVL-1].pp;

  always_comb begin
    sum_d  = p_bit ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign S    = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_brent_kung_adder16.sv
// -----------------------------------------------------------------------------
// tb_brent_kung_adder16
//   Directed and randomized checks of the registered 16-bit adder.
//   The expected values come from a plain arithmetic model: A + B + Cin,
//   computed at 17 bits.
// -----------------------------------------------------------------------------
module tb_brent_kung_adder16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] s;
  logic        cout;

  int vectors;
  int miscompares;

  logic [15:0] vec_tbl [16];

  brent_kung_adder16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .S     (s),
    .Cout  (cout)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the full 17-bit arithmetic sum.
  function automatic logic [16:0] refSum(input logic [15:0] x, input logic [15:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Compare the registered result with the expected 17-bit value.
  task automatic checkOutput(input string tag, input logic [16:0] expected);
    vectors++;
    assert ({cout, s} === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed {Cout,S}=%h expected %h", tag, {cout, s}, expected);
    end
  endtask

  // Drive the operands on the falling edge.
  // Let one rising edge capture them, then sample 1 unit later.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    a   = x;
    b   = y;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Hold reset with the operands that would give the maximum result.
    rst_n = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    cin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 17'h0_0000);

    // Release reset. The first edge captures the present operands.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", refSum(16'hFFFF, 16'hFFFF, 1'b1));

    // Directed boundary patterns.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("full_propagate", 17'h1_0000);
    applyStimulus(16'h5555, 16'hAAAA, 1'b0);
    checkOutput("alt_cin0", 17'h0_FFFF);
    applyStimulus(16'hAAAA, 16'h5555, 1'b1);
    checkOutput("alt_cin1", 17'h1_0000);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    checkOutput("maximum", 17'h1_FFFF);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("zero", 17'h0_0000);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    checkOutput("cin_ripple", 17'h1_0000);

    // Assert reset in the middle of a cycle. The outputs must clear at once.
    applyStimulus(16'h1234, 16'h4321, 1'b1);
    checkOutput("pre_midreset", refSum(16'h1234, 16'h4321, 1'b1));
    @(negedge clk);
    a     = 16'h8000;
    b     = 16'h8000;
    cin   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", 17'h0_0000);
    @(posedge clk);
    #1;
    checkOutput("midreset_hold", 17'h0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_release", 17'h1_0000);

    // Cross product over a 16-entry table: boundary values plus random fill.
    vec_tbl[0] = 16'h0000;
    vec_tbl[1] = 16'h0001;
    vec_tbl[2] = 16'hFFFF;
    vec_tbl[3] = 16'h8000;
    vec_tbl[4] = 16'h7FFF;
    vec_tbl[5] = 16'h5555;
    vec_tbl[6] = 16'hAAAA;
    for (int k = 7; k < 16; k++) begin
      vec_tbl[k] = 16'($urandom);
    end

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          applyStimulus(vec_tbl[i], vec_tbl[j], c[0]);
          checkOutput("cross", refSum(vec_tbl[i], vec_tbl[j], c[0]));
        end
      end
    end

    // Fully random operands and carry-in.
    for (int k = 0; k < 200; k++) begin
      logic [15:0] rx;
      logic [15:0] ry;
      logic        rc;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      applyStimulus(rx, ry, rc);
      checkOutput("random", refSum(rx, ry, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
